uart_rx_core: RTL



---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_rx_core.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-sequencing states used by the receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the rx line plus a 5-sample history of the synchronised value.
// hold_high reports that the four samples preceding in_sample were all high.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic in_sample,
  output logic hold_high
);

  logic       meta;
  logic [4:0] hist;

  // Reset to the idle (high) line level so a held-high line arms immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      hist <= '1;
    end else begin
      meta <= in;
      hist <= {hist[3:0], meta};
    end
  end

  assign in_sample = hist[0];
  assign hold_high = &hist[4:1];

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver running on the oversample tick; parity is compiled in with UART_RX_PARITY_EN.
// Result outputs (done / frame_err / parity_err / out) are held for OVERSAMPLE ticks after each frame.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in,
  output logic                 busy,
  output logic                 done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic [DATA_BITS-1:0] out
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] PRE  = CW'(OVERSAMPLE - 2);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE > 64 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
    $error("OVERSAMPLE must be a power of two in 8..64");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
    $error("PARITY_ODD must be 0 or 1");
  end

  uart_state_t          state;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        hold_cnt;
  logic [IW-1:0]        bit_index;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] data;
  logic                 frame_pend;
  logic                 fin;
  logic                 in_sample;
  logic                 hold_high;

`ifdef UART_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic par_acc;
  logic par_pend;
  logic par_flag;
  assign parity_err = par_flag;
`else
  localparam logic par_pend = 1'b0;
  assign parity_err = 1'b0;
`endif

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_sample (in_sample),
    .hold_high (hold_high)
  );

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_index  <= '0;
      stop_idx   <= 1'b0;
      hold_cnt   <= '0;
      data       <= '0;
      frame_pend <= 1'b0;
      fin        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      out        <= '0;
`ifdef UART_RX_PARITY_EN
      par_acc    <= 1'b0;
      par_pend   <= 1'b0;
      par_flag   <= 1'b0;
`endif
    end else begin
      fin <= 1'b0;

      // Result stage one tick after the last stop sample; the hold timer is reloaded on every frame.
      if (fin) begin
        busy      <= 1'b0;
        hold_cnt  <= LAST;
        done      <= !(frame_pend || par_pend);
        frame_err <= frame_pend;
        out       <= (frame_pend || par_pend) ? '0 : data;
`ifdef UART_RX_PARITY_EN
        par_flag  <= par_pend;
`endif
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end else begin
        done      <= 1'b0;
        frame_err <= 1'b0;
        out       <= '0;
`ifdef UART_RX_PARITY_EN
        par_flag  <= 1'b0;
`endif
      end

      case (state)
        IDLE: begin
          if (!in_sample && (cnt != '0 || hold_high)) begin
            if (cnt == HALF) begin
              // cnt starts at 1 so the data mid-points fall where cnt wraps from LAST.
              state      <= START;
              cnt        <= CW'(1);
              busy       <= 1'b1;
              bit_index  <= '0;
              stop_idx   <= 1'b0;
              frame_pend <= 1'b0;
`ifdef UART_RX_PARITY_EN
              par_acc    <= 1'b0;
              par_pend   <= 1'b0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
        end
        START: begin
          cnt <= cnt + 1'b1;
          if (cnt == PRE) state <= DATA;
        end
        DATA: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            data[bit_index] <= in_sample;
`ifdef UART_RX_PARITY_EN
            par_acc <= par_acc ^ in_sample;
`endif
            if (bit_index == IW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_index <= bit_index + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            par_pend <= in_sample ^ par_acc ^ ODD;
            state    <= STOP;
          end
        end
`endif
        STOP: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            frame_pend <= frame_pend | ~in_sample;
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              state <= IDLE;
              cnt   <= '0;
              fin   <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
